// File: rtl/brq_arb_pkg.sv
// Shared types and helpers for the Buraq IF/LSU memory-port arbiter.
package brq_arb_pkg;

  typedef enum logic {OWN_IF, OWN_LSU} brq_owner_e;

  typedef enum logic {ARB_IDLE, ARB_WAIT} brq_arb_state_e;

  localparam int BRQ_ARB_NREQ = 2;

  function automatic brq_owner_e brq_other_owner(input brq_owner_e own);
    return (own == OWN_IF) ? OWN_LSU : OWN_IF;
  endfunction

endpackage

// File: rtl/brq_arb_pick.sv
// Combinational IF/LSU winner selection. BRQ_ARB_ROUND_ROBIN_EN enables round-robin
// on contention (with a `last` input); otherwise the LSU has fixed priority.
module brq_arb_pick
  import brq_arb_pkg::*;
(
`ifdef BRQ_ARB_ROUND_ROBIN_EN
  input  brq_owner_e last,
`endif
  input  logic       if_req,
  input  logic       lsu_req,
  output brq_owner_e winner
);

  // Winner is only meaningful when at least one request is asserted.
  always_comb begin
    winner = OWN_IF;
    if (if_req && lsu_req) begin
`ifdef BRQ_ARB_ROUND_ROBIN_EN
      winner = brq_other_owner(last);
`else
      winner = OWN_LSU;
`endif
    end else if (lsu_req) begin
      winner = OWN_LSU;
    end else begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/brq_mem_arbiter.sv
// Shares the unified memory port between IF and LSU, one transaction outstanding.
// Optional macro BRQ_ARB_ROUND_ROBIN_EN selects round-robin instead of LSU priority.
module brq_mem_arbiter
  import brq_arb_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                   brq_clk,
  input  logic                   brq_rst,
  input  logic                   if_req_i,
  input  logic [AddrWidth-1:0]   if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [DataWidth-1:0]   if_rdata_o,
  input  logic                   lsu_req_i,
  input  logic                   lsu_we_i,
  input  logic [DataWidth/8-1:0] lsu_be_i,
  input  logic [AddrWidth-1:0]   lsu_addr_i,
  input  logic [DataWidth-1:0]   lsu_wdata_i,
  output logic                   lsu_gnt_o,
  output logic                   lsu_rvalid_o,
  output logic [DataWidth-1:0]   lsu_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int BeWidth = DataWidth / 8;

  brq_arb_state_e state_r, state_next_s;
  brq_owner_e     owner_r, owner_next_s, winner_s;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
  brq_owner_e     last_r, last_next_s;
`endif
  logic issue_s, issue_req_s, grant_s, resp_s;

  // A response frees the port in the same cycle, giving back-to-back issue.
  assign issue_s     = (state_r == ARB_IDLE) || mem_rvalid_i;
  assign issue_req_s = issue_s && (if_req_i || lsu_req_i);
  assign grant_s     = issue_req_s && mem_gnt_i;
  assign resp_s      = (state_r == ARB_WAIT) && mem_rvalid_i;

  assign if_rdata_o  = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;

  brq_arb_pick u_pick (
`ifdef BRQ_ARB_ROUND_ROBIN_EN
    .last    (last_r),
`endif
    .if_req  (if_req_i),
    .lsu_req (lsu_req_i),
    .winner  (winner_s)
  );

  // Request bundle mux, grants and response routing; all held low during reset.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = {BeWidth{1'b0}};
    mem_addr_o   = {AddrWidth{1'b0}};
    mem_wdata_o  = {DataWidth{1'b0}};
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    if (!brq_rst) begin
      if (issue_req_s) begin
        mem_req_o = 1'b1;
        if (winner_s == OWN_LSU) begin
          mem_we_o    = lsu_we_i;
          mem_be_o    = lsu_be_i;
          mem_addr_o  = lsu_addr_i;
          mem_wdata_o = lsu_wdata_i;
          lsu_gnt_o   = mem_gnt_i;
        end else begin
          mem_we_o    = 1'b0;
          mem_be_o    = {BeWidth{1'b1}};
          mem_addr_o  = if_addr_i;
          mem_wdata_o = {DataWidth{1'b0}};
          if_gnt_o    = mem_gnt_i;
        end
      end else begin
        mem_req_o = 1'b0;
      end
      if (resp_s) begin
        if (owner_r == OWN_LSU) begin
          lsu_rvalid_o = 1'b1;
        end else begin
          if_rvalid_o = 1'b1;
        end
      end else begin
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;
      end
    end else begin
      mem_req_o = 1'b0;
    end
  end

  // Next-state logic: a grant always opens a new transaction owned by the winner.
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
    last_next_s  = last_r;
`endif
    if (grant_s) begin
      state_next_s = ARB_WAIT;
      owner_next_s = winner_s;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
      last_next_s  = winner_s;
`endif
    end else if (issue_s) begin
      state_next_s = ARB_IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // State, owner and last-granted registers.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_r <= ARB_IDLE;
      owner_r <= OWN_IF;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
      last_r  <= OWN_IF;
`endif
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
`ifdef BRQ_ARB_ROUND_ROBIN_EN
      last_r  <= last_next_s;
`endif
    end
  end

endmodule
